alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4, meaning maximum operand width in bytes (legal range 2..4).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, meaning the reset: asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1, meaning an operation request is present.
REQ-005 SHALL have port req_ready, output, 1, meaning the controller can accept a request.
REQ-006 SHALL have ports req_a and req_b, input, 8*NBYTES, meaning the operands.
REQ-007 SHALL have ports req_sel (input, 4) and req_mode (input, 1), meaning the ALU function and mode, held for the whole operation.
REQ-008 SHALL have port req_cin, input, 1, meaning the carry into byte 0.
REQ-009 SHALL have port req_len, input, 2, meaning the active byte count minus 1.
REQ-010 SHALL have ports alu_a and alu_b, output, 8, meaning the byte operands driven to the external alu8.
REQ-011 SHALL have ports alu_sel (output, 4), alu_mode (output, 1) and alu_cin (output, 1), meaning the controls driven to the external alu8.
REQ-012 SHALL have ports alu_result (input, 8) and alu_cout (input, 1), meaning the combinational alu8 response.
REQ-013 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), meaning the response handshake.
REQ-014 SHALL have ports rsp_result (output, 8*NBYTES) and rsp_cout (output, 1), meaning the assembled result and final carry.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; req_ready = (state==IDLE).
REQ-016 SHALL, on req_valid && req_ready: latch a, b, sel, mode, cin and len; clear the result register; set byte index 0; enter EXEC.
REQ-017 SHALL, in EXEC:
- drive alu_a/alu_b with byte[idx] of the latched operands, and alu_sel/alu_mode with the latched values;
- capture alu_result into result byte[idx] at the clock edge;
- advance idx by one per cycle.
REQ-018 SHALL drive alu_cin = latched cin when idx==0, else the alu_cout registered from the previous byte.
REQ-019 SHALL, when latched mode==1 (logic), force alu_cin=0 and rsp_cout=0.
REQ-020 SHALL leave EXEC after the cycle where idx==len and enter DONE; EXEC lasts exactly len+1 cycles.
REQ-021 SHALL clamp a req_len value >= NBYTES to NBYTES-1.
REQ-022 SHALL hold result bytes above len at 0.
REQ-023 SHALL, in DONE:
- assert rsp_valid;
- hold rsp_result and rsp_cout stable (rsp_cout = alu_cout of the last byte);
- return to IDLE on rsp_ready.
REQ-024 SHALL, with rsp_ready held high, give a latency of len+2 cycles from accept to response handshake.
REQ-025 SHALL deassert req_ready in EXEC and DONE; requests presented then are neither accepted nor lost (the requester holds them).
REQ-026 SHALL drive alu_a, alu_b and alu_cin to 0 outside EXEC.

Reset
REQ-027 SHALL, on rst assertion including mid-operation, immediately abort and enter IDLE.
REQ-028 SHALL reset the registered outputs to: rsp_valid=0, rsp_result=0, rsp_cout=0, idx=0, all latched fields 0.
REQ-029 SHALL drive req_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, with ALU_SEQ_FLAGS_EN defined, add output rsp_zero (1 bit), which is 1 in DONE iff all active result bytes are 0.
REQ-031 SHALL, with ALU_SEQ_FLAGS_EN defined, add output rsp_ovf (1 bit), which in arithmetic mode is the signed overflow of the top active byte (operand sign bits vs result sign bit), and 0 in logic mode.
REQ-032 SHALL, with ALU_SEQ_FLAGS_EN undefined, have neither port nor their logic.

Structure
REQ-033 SHALL take the state enum (IDLE, EXEC, DONE) and the named select constants SEL_ADD=4'b1001 and SEL_SUB=4'b0110 from the shared package alu_seq_pkg.
REQ-034 SHALL contain no sub-module; alu8 is instantiated beside it by the parent.

Verification
REQ-035 SHALL verify: len=3, sel=SEL_ADD, mode=0, a=0x000000FF, b=0x00000001 -> rsp_result=0x00000100, carry chained across bytes 0-1, rsp_valid at cycle 5 after accept.
REQ-036 SHALL verify: len=1, mode=1, sel=4'b1011 (A AND B), a=0xF0F0, b=0xFF00 -> rsp_result=0x0000F000, rsp_cout=0, alu_cin=0 in every cycle.
REQ-037 SHALL verify: len=0, a=0x12 -> EXEC lasts 1 cycle; result bytes 1..3 equal 0.
REQ-038 SHALL verify: rsp_ready held low for 5 cycles in DONE -> rsp_result stable; a second request offered then is not accepted until 1 cycle after the handshake.
REQ-039 SHALL verify: rst asserted during EXEC at idx=2 -> next cycle state IDLE, rsp_valid=0, req_ready=1 after release, following operation correct.
REQ-040 SHALL verify: ALU_SEQ_FLAGS_EN defined, len=0, SEL_SUB, a=0x80, b=0x01 -> rsp_zero=0, rsp_ovf=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the byte-serial ALU sequencer.
package alu_seq_pkg;

  // Controller phases: waiting for work, stepping bytes, holding the response
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // alu8 function selects with a named meaning in arithmetic mode
  localparam logic [3:0] SEL_ADD = 4'b1001;
  localparam logic [3:0] SEL_SUB = 4'b0110;

endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: steps a multi-byte operation through an external 8-bit alu8,
// one byte per cycle from byte 0 upward, chaining the carry between bytes,
// and presents the assembled result on a valid/ready response port.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds the rsp_zero / rsp_ovf flags.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic [3:0]            req_sel,
  input  logic                  req_mode,
  input  logic                  req_cin,
  input  logic [1:0]            req_len,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [3:0]            alu_sel,
  output logic                  alu_mode,
  output logic                  alu_cin,
  input  logic [7:0]            alu_result,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_result,
  output logic                  rsp_cout
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                  rsp_zero,
  output logic                  rsp_ovf
`endif
);

  localparam int W = 8 * NBYTES;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     sel_q;
  logic           mode_q;
  logic           cin_q;
  logic [1:0]     len_q;
  logic [1:0]     idx_q;
  logic           cout_q;   // carry out of the previous byte; final carry in DONE

  logic [1:0]     len_clamped;
  logic           accept;
  logic           last_byte;
  logic [7:0]     a_byte, b_byte;

  assign accept    = req_valid && (state_q == IDLE);
  assign last_byte = (idx_q == len_q);

  // Requests longer than the operand width are shortened to the full width
  always_comb begin
    len_clamped = req_len;
    if ({1'b0, req_len} >= 3'(NBYTES))
      len_clamped = 2'(NBYTES - 1);
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: one EXEC cycle per active byte, then hold DONE until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)  state_d = EXEC;
      EXEC:    if (last_byte)  state_d = DONE;
      DONE:    if (rsp_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; the alu8 byte lanes are quiet outside EXEC
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    alu_sel   = sel_q;
    alu_mode  = mode_q;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_cin   = 1'b0;
    if (state_q == EXEC) begin
      alu_a = a_byte;
      alu_b = b_byte;
      if (!mode_q)
        alu_cin = (idx_q == 2'd0) ? cin_q : cout_q;
    end
  end

  // Select the operand bytes addressed by the current index
  always_comb begin
    a_byte = 8'h00;
    b_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == 2'(i)) begin
        a_byte = a_q[i*8 +: 8];
        b_byte = b_q[i*8 +: 8];
      end
    end
  end

  // Merge this cycle's alu8 byte into the result at the current index
  always_comb begin
    result_d = result_q;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == 2'(i))
        result_d[i*8 +: 8] = alu_result;
    end
  end

  // Operand latch, byte index, result assembly and carry chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      mode_q   <= 1'b0;
      cin_q    <= 1'b0;
      len_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (accept) begin
      a_q      <= req_a;
      b_q      <= req_b;
      sel_q    <= req_sel;
      mode_q   <= req_mode;
      cin_q    <= req_cin;
      len_q    <= len_clamped;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      result_q <= result_d;
      cout_q   <= mode_q ? 1'b0 : alu_cout;
      if (!last_byte)
        idx_q <= idx_q + 2'd1;
    end
  end

  assign rsp_result = result_q;
  assign rsp_cout   = cout_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic sa, sb, sr;

  // Sign bits of the top active byte feed the signed-overflow flag
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    sr = 1'b0;
    for (int i = 0; i < NBYTES; i++) begin
      if (len_q == 2'(i)) begin
        sa = a_q[i*8 + 7];
        sb = b_q[i*8 + 7];
        sr = result_q[i*8 + 7];
      end
    end
  end

  // Bytes above len are held at zero, so a whole-word test covers the active bytes
  assign rsp_zero = (state_q == DONE) && (result_q == '0);
  assign rsp_ovf  = (state_q == DONE) && !mode_q &&
                    ((sel_q == SEL_SUB) ? ((sa != sb) && (sr != sa))
                                        : ((sa == sb) && (sr != sa)));
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural alu8 stub beside the DUT, directed
// scenarios plus random operations checked against a whole-word model.
// Build with ALU_SEQ_FLAGS_EN defined to also check the flag outputs.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        mode;
    logic        cin;
    logic [1:0]  len;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [3:0]  req_sel = '0;
  logic        req_mode = 1'b0, req_cin = 1'b0;
  logic [1:0]  req_len = '0;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [3:0]  alu_sel;
  logic        alu_mode, alu_cin, alu_cout;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_cout;
`ifdef ALU_SEQ_FLAGS_EN
  logic        rsp_zero, rsp_ovf;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_mode(req_mode),
    .req_cin(req_cin), .req_len(req_len),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_mode(alu_mode),
    .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout)
`ifdef ALU_SEQ_FLAGS_EN
    , .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf)
`endif
  );

  // alu8 stand-in: a few logic functions and add/sub with carry
  always_comb begin
    alu_cout   = 1'b0;
    alu_result = 8'h00;
    if (alu_mode) begin
      case (alu_sel)
        4'b1011: alu_result = alu_a & alu_b;
        4'b1110: alu_result = alu_a | alu_b;
        4'b0110: alu_result = alu_a ^ alu_b;
        default: alu_result = ~alu_a;
      endcase
    end else begin
      case (alu_sel)
        SEL_ADD: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
        SEL_SUB: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_cin};
        default: {alu_cout, alu_result} = {1'b0, alu_a} + {8'h00, alu_cin};
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: result over the active width, carry out of its top bit
  function automatic void model(input op_t o, output logic [31:0] r, output logic c,
                                output logic z, output logic v);
    int          w;
    logic [32:0] m, s;
    logic [31:0] bb;
    logic        sa, sb, sr;
    w = 8 * (int'(o.len) + 1);
    m = (33'd1 << w) - 33'd1;
    c = 1'b0;
    if (o.mode) begin
      case (o.sel)
        4'b1011: r = o.a & o.b;
        4'b1110: r = o.a | o.b;
        4'b0110: r = o.a ^ o.b;
        default: r = ~o.a;
      endcase
      r = r & m[31:0];
    end else begin
      bb = (o.sel == SEL_SUB) ? ~o.b : o.b;
      s  = {1'b0, o.a & m[31:0]} + {1'b0, bb & m[31:0]} + {32'd0, o.cin};
      r  = s[31:0] & m[31:0];
      c  = s[w];
    end
    z  = (r == 32'd0);
    sa = o.a[w-1];
    sb = o.b[w-1];
    sr = r[w-1];
    if (o.mode)               v = 1'b0;
    else if (o.sel == SEL_SUB) v = (sa != sb) && (sr != sa);
    else                      v = (sa == sb) && (sr != sa);
  endfunction

  // Carry expected into byte k of an arithmetic operation
  function automatic logic carry_into(input op_t o, input int k);
    logic [32:0] m, s;
    logic [31:0] bb;
    if (k == 0) return o.cin;
    m  = (33'd1 << (8 * k)) - 33'd1;
    bb = (o.sel == SEL_SUB) ? ~o.b : o.b;
    s  = {1'b0, o.a & m[31:0]} + {1'b0, bb & m[31:0]} + {32'd0, o.cin};
    return s[8 * k];
  endfunction

  task automatic drive(input op_t o);
    req_a = o.a; req_b = o.b; req_sel = o.sel; req_mode = o.mode;
    req_cin = o.cin; req_len = o.len; req_valid = 1'b1;
  endtask

  // One full operation: accept, byte-by-byte EXEC, response with optional
  // back-pressure, optionally offering the next request while held in DONE
  task automatic run_op(input op_t o, input int hold, input bit offer, input op_t nxt);
    logic [31:0] er;
    logic        ec, ez, ev;
    int          ex;
    model(o, er, ec, ez, ev);
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_alu_ab", {alu_a, alu_b, alu_cin}, 0);
    drive(o);
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    ex = 0;
    @(negedge clk);
    while (!rsp_valid && ex < 20) begin
      chk("exec_req_ready", req_ready, 0);
      chk("exec_alu_a", alu_a, o.a[ex*8 +: 8]);
      chk("exec_alu_b", alu_b, o.b[ex*8 +: 8]);
      chk("exec_alu_ctl", {alu_sel, alu_mode}, {o.sel, o.mode});
      chk("exec_alu_cin", alu_cin, o.mode ? 1'b0 : carry_into(o, ex));
      ex++;
      @(negedge clk);
    end
    chk("rsp_valid", rsp_valid, 1);
    if (!rsp_valid) return;
    chk("exec_cycles", ex, int'(o.len) + 1);
    chk("rsp_result", rsp_result, er);
    chk("rsp_cout", rsp_cout, ec);
`ifdef ALU_SEQ_FLAGS_EN
    chk("rsp_zero", rsp_zero, ez);
    chk("rsp_ovf", rsp_ovf, ev);
`endif
    for (int h = 0; h < hold; h++) begin
      if (offer && h == 0) drive(nxt);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_result", {rsp_result, rsp_cout}, {er, ec});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    op_t o, n;
    n = '{a: 0, b: 0, sel: 0, mode: 0, cin: 0, len: 0};
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_alu_a", alu_a, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);

    // Carry ripple from byte 0 into byte 1
    o = '{a: 32'h000000FF, b: 32'h00000001, sel: SEL_ADD, mode: 0, cin: 0, len: 3};
    run_op(o, 0, 0, n);
    // Logic AND over two bytes: no carry ever
    o = '{a: 32'h0000F0F0, b: 32'h0000FF00, sel: 4'b1011, mode: 1, cin: 1, len: 1};
    run_op(o, 0, 0, n);
    // Single byte; upper result bytes stay zero
    o = '{a: 32'h00000012, b: 32'hFFFFFF34, sel: SEL_ADD, mode: 0, cin: 0, len: 0};
    run_op(o, 0, 0, n);
    // Back-pressure in DONE with the next request already offered
    o = '{a: 32'h12345678, b: 32'h11111111, sel: SEL_SUB, mode: 0, cin: 1, len: 3};
    n = '{a: 32'h0000ABCD, b: 32'h00001234, sel: SEL_ADD, mode: 0, cin: 1, len: 1};
    run_op(o, 5, 1, n);
    run_op(n, 0, 0, n);
    // Signed overflow on a single-byte subtract
    o = '{a: 32'h00000080, b: 32'h00000001, sel: SEL_SUB, mode: 0, cin: 1, len: 0};
    run_op(o, 0, 0, n);

    // Reset in the middle of EXEC at byte index 2
    o = '{a: 32'hA1B2C3D4, b: 32'h01020304, sel: SEL_ADD, mode: 0, cin: 0, len: 3};
    @(negedge clk);
    drive(o);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_alu_a_idx2", alu_a, 8'hB2);
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_result", rsp_result, 0);
    chk("abort_alu_a", alu_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", req_ready, 1);
    o = '{a: 32'h00FF00FF, b: 32'h00010001, sel: SEL_ADD, mode: 0, cin: 1, len: 2};
    run_op(o, 0, 0, n);

    // Random operations with occasional back-pressure
    for (int i = 0; i < 40; i++) begin
      o.a    = $urandom;
      o.b    = $urandom;
      o.mode = $urandom_range(0, 1);
      o.cin  = $urandom_range(0, 1);
      o.len  = 2'($urandom_range(0, 3));
      if (o.mode) begin
        case ($urandom_range(0, 2))
          0:       o.sel = 4'b1011;
          1:       o.sel = 4'b1110;
          default: o.sel = 4'b0110;
        endcase
      end else begin
        o.sel = $urandom_range(0, 1) ? SEL_ADD : SEL_SUB;
      end
      run_op(o, $urandom_range(0, 2), 0, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
